nrs_pilot_fetch_ctrl: RTL and testbench
=======================================

NRS_PILOT_FETCH_CTRL -- requirements
Module: nrs_pilot_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning pilot RE width: {I[15:0], Q[15:0]}.
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port start  input  1  one-cycle pulse requesting extraction of the 4 NRS pilots of one buffered subframe.
REQ-005 The block SHALL have port abort  input  1  synchronous cancel of an extraction in progress.
REQ-006 The block SHALL have port cell_id  input  9  N_cell_ID, 0..503, sampled only on an accepted start.
REQ-007 The block SHALL have port idx_cell_id  output  9  registered cell ID, driven to the NRS index generator.
REQ-008 The block SHALL have port est_rd_addr  output  2  pilot select (0..3), driven to the NRS index generator.
REQ-009 The block SHALL have port index_demap  input  4  subcarrier row, returned combinationally by the index generator.
REQ-010 The block SHALL have port mem_rd_en  output  1  read strobe to the RE grid RAM.
REQ-011 The block SHALL have port mem_rd_row  output  4  grid row (subcarrier 0..11).
REQ-012 The block SHALL have port mem_rd_col  output  4  grid column (OFDM symbol 0..13).
REQ-013 The block SHALL have port mem_rd_data  input  DATA_W  grid RAM read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 The block SHALL have port pilot_data  output  DATA_W  registered pilot RE.
REQ-015 The block SHALL have port pilot_idx  output  2  est_rd_addr value that produced pilot_data.
REQ-016 The block SHALL have ports pilot_valid (output, 1), pilot_ready (input, 1) and pilot_last (output, 1; high with the pilot_idx=3 beat), forming a valid/ready handshake to the channel estimator.
REQ-017 The block SHALL have ports busy (output, 1; high in every state except IDLE) and done (output, 1; one-cycle completion pulse).

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, READ, WAIT, HOLD and DONE; it SHALL also hold a 2-bit pilot counter k.
REQ-019 IDLE: a start pulse SHALL load cell_id into idx_cell_id, clear k to 0 and move to SETUP; start SHALL be ignored in every other state.
REQ-020 SETUP SHALL last exactly 1 cycle so the index generator output settles, then move to READ.
REQ-021 est_rd_addr SHALL equal k in all states.
REQ-022 READ SHALL last 1 cycle: mem_rd_en=1, mem_rd_row=index_demap, mem_rd_col from a fixed table on k (0->5, 1->6, 2->12, 3->13); then move to WAIT.
REQ-023 mem_rd_en SHALL be 0 in every state other than READ.
REQ-024 WAIT SHALL capture mem_rd_data into pilot_data and k into pilot_idx, set pilot_valid=1 and pilot_last=(k==3), then move to HOLD.
REQ-025 HOLD: pilot_data, pilot_idx and pilot_last SHALL stay stable while pilot_valid=1 and pilot_ready=0; a stall of any length SHALL be allowed.
REQ-026 HOLD, when pilot_valid and pilot_ready are both 1: pilot_valid SHALL clear next cycle; if k<3 the FSM SHALL set k to k+1 and go to READ, and if k==3 it SHALL go to DONE.
REQ-027 DONE SHALL assert done=1 for exactly 1 cycle, then return to IDLE; done SHALL be 0 in every other state.
REQ-028 Throughput SHALL be at most 1 pilot per 3 cycles; only 1 read SHALL be outstanding at any time.
REQ-029 Latency SHALL be: start accepted at edge t -> SETUP in cycle t+1 -> mem_rd_en high in cycle t+2 -> first pilot_valid high in cycle t+4.
REQ-030 abort in any non-IDLE state SHALL return the FSM to IDLE on the next edge, clear pilot_valid and pilot_last, produce no done pulse, and discard any in-flight read data.
REQ-031 abort SHALL take priority over a handshake in the same cycle.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 Simultaneous start and abort while in IDLE SHALL accept start.
REQ-034 A start arriving in the same cycle as done SHALL be ignored; a new start is accepted from IDLE only.
REQ-035 idx_cell_id SHALL hold its value across abort and until the next accepted start.

Reset
REQ-036 rst_n=0 sampled at a clock edge SHALL force: state IDLE, k=0, idx_cell_id=0, pilot_data=0, pilot_idx=0, pilot_valid=0, pilot_last=0, mem_rd_en=0, mem_rd_row=0, mem_rd_col=0, busy=0, done=0.
REQ-037 Reset mid-extraction SHALL take effect on the next edge, regardless of handshake state, and no done pulse SHALL follow.

Verification
REQ-038 cell_id=0, pilot_ready=1 held -> rows 0,6,3,9 at cols 5,6,12,13; pilot_idx 0..3; pilot_last on the 4th beat; done 1 cycle after the 4th handshake.
REQ-039 cell_id=4 -> rows 4,10,7,1; cell_id=503 -> rows 5,11,8,2; first pilot_valid exactly 4 cycles after start.
REQ-040 pilot_ready low for 5 cycles on beat 1 -> pilot_data/pilot_idx stable throughout, no extra mem_rd_en, sequence resumes unchanged.
REQ-041 abort asserted in WAIT of beat 2 -> IDLE next cycle, pilot_valid=0, no done; a following start with cell_id=7 -> rows 1,7,4,10.
REQ-042 start pulses while busy and in the same cycle as done -> ignored; exactly 4 beats and 1 done per accepted start.
REQ-043 rst_n low for 1 cycle during HOLD -> all outputs at reset values next cycle; no done pulse.

Source files
------------

// File: rtl/nrs_pilot_fetch_ctrl_if.sv
// NRS pilot stream bundle toward the channel estimator.
// Valid/ready handshake carrying one pilot RE per beat.
interface nrs_pilot_fetch_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] pilot_data;
  logic [1:0]        pilot_idx;
  logic              pilot_valid;
  logic              pilot_ready;
  logic              pilot_last;

  modport master (
    output pilot_data,
    output pilot_idx,
    output pilot_valid,
    output pilot_last,
    input  pilot_ready
  );

  modport slave (
    input  pilot_data,
    input  pilot_idx,
    input  pilot_valid,
    input  pilot_last,
    output pilot_ready
  );
endinterface

// File: rtl/nrs_pilot_fetch_ctrl.sv
// NRS pilot fetch controller: reads the 4 NRS pilot REs
// of one buffered subframe and streams them out.
module nrs_pilot_fetch_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [8:0]        cell_id,
  output logic [8:0]        idx_cell_id,
  output logic [1:0]        est_rd_addr,
  input  logic [3:0]        index_demap,
  output logic              mem_rd_en,
  output logic [3:0]        mem_rd_row,
  output logic [3:0]        mem_rd_col,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  nrs_pilot_fetch_ctrl_if.master pilot
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    WAIT,
    HOLD,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] k;
  logic [1:0] k_nx;
  logic       ld;
  logic       cap;
  logic       hs;
  logic       kill;

  assign est_rd_addr = k;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, read strobe and datapath controls
  always_comb begin
    state_nx   = state;
    k_nx       = k;
    ld         = 1'b0;
    cap        = 1'b0;
    hs         = 1'b0;
    mem_rd_en  = 1'b0;
    mem_rd_row = 4'd0;
    mem_rd_col = 4'd0;
    done       = 1'b0;
    busy       = (state != IDLE);
    kill       = abort && (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) begin
          ld       = 1'b1;
          k_nx     = 2'd0;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        state_nx = READ;
      end
      READ: begin
        mem_rd_en  = 1'b1;
        mem_rd_row = index_demap;
        unique case (k)
          2'd0: mem_rd_col = 4'd5;
          2'd1: mem_rd_col = 4'd6;
          2'd2: mem_rd_col = 4'd12;
          2'd3: mem_rd_col = 4'd13;
          default: mem_rd_col = 4'd0;
        endcase
        state_nx = WAIT;
      end
      WAIT: begin
        cap      = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (pilot.pilot_valid && pilot.pilot_ready) begin
          hs = 1'b1;
          if (k == 2'd3) begin
            state_nx = DONE;
          end else begin
            k_nx     = k + 2'd1;
            state_nx = READ;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // Cancel wins over any handshake or capture
    if (kill) begin
      state_nx = IDLE;
      k_nx     = k;
      ld       = 1'b0;
      cap      = 1'b0;
      hs       = 1'b0;
    end
  end

  // Pilot counter, cell ID and output pilot registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k                 <= 2'd0;
      idx_cell_id       <= 9'd0;
      pilot.pilot_data  <= '0;
      pilot.pilot_idx   <= 2'd0;
      pilot.pilot_valid <= 1'b0;
      pilot.pilot_last  <= 1'b0;
    end else begin
      k <= k_nx;
      if (ld) begin
        idx_cell_id <= cell_id;
      end
      if (kill) begin
        pilot.pilot_valid <= 1'b0;
        pilot.pilot_last  <= 1'b0;
      end else if (cap) begin
        pilot.pilot_data  <= mem_rd_data;
        pilot.pilot_idx   <= k;
        pilot.pilot_valid <= 1'b1;
        pilot.pilot_last  <= (k == 2'd3);
      end else if (hs) begin
        pilot.pilot_valid <= 1'b0;
        pilot.pilot_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nrs_pilot_fetch_ctrl.sv
// Directed bench for nrs_pilot_fetch_ctrl with index
// generator and grid RAM models.
module tb_nrs_pilot_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [8:0]  cell_id;
  logic [8:0]  idx_cell_id;
  logic [1:0]  est_rd_addr;
  logic [3:0]  index_demap;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_row;
  logic [3:0]  mem_rd_col;
  logic [31:0] mem_rd_data;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int n_done   = 0;

  nrs_pilot_fetch_ctrl_if #(.DATA_W(32)) pif ();

  nrs_pilot_fetch_ctrl #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cell_id     (cell_id),
    .idx_cell_id (idx_cell_id),
    .est_rd_addr (est_rd_addr),
    .index_demap (index_demap),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_row  (mem_rd_row),
    .mem_rd_col  (mem_rd_col),
    .mem_rd_data (mem_rd_data),
    .busy        (busy),
    .done        (done),
    .pilot       (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NRS index generator: v = cell mod 6, offsets 0,6,3,9
  function automatic logic [3:0] nrs_row(
    input logic [8:0] c,
    input logic [1:0] p
  );
    int v;
    v = int'(c) % 6;
    case (p)
      2'd0: v = v;
      2'd1: v = v + 6;
      2'd2: v = (v + 3) % 12;
      default: v = (v + 9) % 12;
    endcase
    return 4'(v);
  endfunction

  assign index_demap = nrs_row(idx_cell_id, est_rd_addr);

  // Grid RAM: 1-cycle read, garbage when not read
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rd_data <= {16'hC0DE, 4'h0, mem_rd_row,
                      4'h0, mem_rd_col};
    else
      mem_rd_data <= 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (mem_rd_en) n_rd <= n_rd + 1;
    if (done) n_done <= n_done + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_row", 32'(mem_rd_row), 0);
    chk("rst_col", 32'(mem_rd_col), 0);
    chk("rst_cell", 32'(idx_cell_id), 0);
    chk("rst_addr", 32'(est_rd_addr), 0);
    chk("rst_valid", 32'(pif.pilot_valid), 0);
    chk("rst_last", 32'(pif.pilot_last), 0);
    chk("rst_data", pif.pilot_data, 0);
    chk("rst_idx", 32'(pif.pilot_idx), 0);
  endtask

  // One extraction; rows packed 4 bits per beat, beat 0 in LSBs
  task automatic run(
    input logic [8:0]  cid,
    input logic [15:0] rows,
    input int          stall_beat,
    input bit          start_in_busy,
    input bit          start_at_done,
    input bit          abort_with_start
  );
    logic [15:0] cols;
    logic [3:0]  r;
    logic [3:0]  c;
    logic [31:0] exp_d;
    int rd0;
    int dn0;
    int rdh;
    cols = 16'hDC65;
    rd0  = n_rd;
    dn0  = n_done;
    cell_id = cid;
    start   = 1'b1;
    abort   = abort_with_start;
    pif.pilot_ready = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("setup_busy", 32'(busy), 1);
    chk("setup_rd_en", 32'(mem_rd_en), 0);
    chk("setup_cell", 32'(idx_cell_id), 32'(cid));
    tick;
    for (int b = 0; b < 4; b++) begin
      r = rows[4*b +: 4];
      c = cols[4*b +: 4];
      exp_d = {16'hC0DE, 4'h0, r, 4'h0, c};
      chk("read_en", 32'(mem_rd_en), 1);
      chk("read_row", 32'(mem_rd_row), 32'(r));
      chk("read_col", 32'(mem_rd_col), 32'(c));
      chk("read_addr", 32'(est_rd_addr), 32'(b));
      chk("read_valid", 32'(pif.pilot_valid), 0);
      tick;
      chk("wait_rd_en", 32'(mem_rd_en), 0);
      chk("wait_valid", 32'(pif.pilot_valid), 0);
      tick;
      chk("hold_valid", 32'(pif.pilot_valid), 1);
      chk("hold_data", pif.pilot_data, exp_d);
      chk("hold_idx", 32'(pif.pilot_idx), 32'(b));
      chk("hold_last", 32'(pif.pilot_last),
          32'(b == 3));
      if (b == 0 && start_in_busy) begin
        start   = 1'b1;
        cell_id = 9'd300;
      end
      if (b == stall_beat) begin
        pif.pilot_ready = 1'b0;
        rdh = n_rd;
        repeat (5) begin
          tick;
          start = 1'b0;
          chk("stall_valid", 32'(pif.pilot_valid), 1);
          chk("stall_data", pif.pilot_data, exp_d);
          chk("stall_idx", 32'(pif.pilot_idx), 32'(b));
          chk("stall_last", 32'(pif.pilot_last),
              32'(b == 3));
          chk("stall_rd", 32'(n_rd), 32'(rdh));
        end
        pif.pilot_ready = 1'b1;
      end
      tick;
      start = 1'b0;
      chk("post_hs_valid", 32'(pif.pilot_valid), 0);
    end
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    chk("done_last", 32'(pif.pilot_last), 0);
    chk("done_rd_en", 32'(mem_rd_en), 0);
    if (start_at_done) begin
      start   = 1'b1;
      cell_id = 9'd200;
    end
    tick;
    start = 1'b0;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cell", 32'(idx_cell_id), 32'(cid));
    tick;
    chk("idle2_busy", 32'(busy), 0);
    chk("reads", 32'(n_rd - rd0), 4);
    chk("dones", 32'(n_done - dn0), 1);
  endtask

  initial begin
    int dn0;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    cell_id = 9'd0;
    pif.pilot_ready = 1'b0;
    tick;
    tick;
    chk_reset_outs();
    rst_n = 1'b1;
    tick;
    chk("idle_after_rst", 32'(busy), 0);

    // cell 0: rows 0,6,3,9
    run(9'd0, 16'h9360, -1, 0, 0, 0);
    // cell 4: rows 4,10,7,1
    run(9'd4, 16'h17A4, -1, 0, 0, 0);
    // cell 503 with stall on beat 1, ignored starts
    run(9'd503, 16'h28B5, 1, 1, 1, 0);

    // abort in IDLE
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_cell", 32'(idx_cell_id), 503);

    // abort in WAIT of beat 2
    dn0 = n_done;
    cell_id = 9'd4;
    start = 1'b1;
    pif.pilot_ready = 1'b1;
    tick;
    start = 1'b0;
    repeat (8) tick;
    chk("ab_pre_addr", 32'(est_rd_addr), 2);
    chk("ab_pre_busy", 32'(busy), 1);
    chk("ab_pre_rd_en", 32'(mem_rd_en), 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_valid", 32'(pif.pilot_valid), 0);
    chk("ab_last", 32'(pif.pilot_last), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_cell", 32'(idx_cell_id), 4);
    tick;
    chk("ab_done2", 32'(done), 0);
    chk("ab_valid2", 32'(pif.pilot_valid), 0);
    chk("ab_ndone", 32'(n_done), 32'(dn0));
    // cell 7: rows 1,7,4,10
    run(9'd7, 16'hA471, -1, 0, 0, 0);

    // start and abort together in IDLE
    run(9'd0, 16'h9360, -1, 0, 0, 1);

    // reset during HOLD of beat 0
    dn0 = n_done;
    cell_id = 9'd503;
    pif.pilot_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    chk("rh_valid", 32'(pif.pilot_valid), 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk_reset_outs();
    tick;
    chk("rh_busy", 32'(busy), 0);
    chk("rh_done", 32'(done), 0);
    tick;
    chk("rh_ndone", 32'(n_done), 32'(dn0));
    run(9'd503, 16'h28B5, -1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
